mm_port_arbiter: RTL

MM_PORT_ARBITER -- requirements
Module: mm_port_arbiter

---
 rtl/mm_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mm_port_arbiter.sv
// mm_port_arbiter: round-robin arbiter giving two line requesters a single-outstanding
// main-memory port, with registered fill return and a sticky wait timeout.
module mm_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rq0_a,
    input  logic              rq0_read,
    input  logic              rq0_write,
    input  logic [255:0]      rq0_wd,
    output logic              rq0_ready,
    output logic [255:0]      rq0_rd,
    output logic              rq0_rd_valid,
    input  logic [ADDR_W-1:0] rq1_a,
    input  logic              rq1_read,
    input  logic              rq1_write,
    input  logic [255:0]      rq1_wd,
    output logic              rq1_ready,
    output logic [255:0]      rq1_rd,
    output logic              rq1_rd_valid,
    output logic [ADDR_W-1:0] mm_a,
    output logic              mm_read,
    output logic              mm_write,
    output logic [255:0]      mm_wd,
    input  logic [255:0]      mm_rd,
    input  logic              mm_rd_valid,
    input  logic              mm_ready,
    output logic              err_timeout,
    output logic              err_owner
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(31);
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner, last;
    logic          req0, req1, grant, win, win_wr, rd_done, wr_done, expire;
    always_comb begin
        req0    = rq0_read | rq0_write;
        req1    = rq1_read | rq1_write;
        grant   = state == IDLE && mm_ready && (req0 || req1);
        win     = (req0 && req1) ? ~last : req1;
        win_wr  = win ? rq1_write : rq0_write;
        rd_done = state == RD_WAIT && mm_rd_valid;
        // the write pulse cycle itself never counts as completion
        wr_done = state == WR_WAIT && !mm_write && mm_ready;
        expire  = state != IDLE && !rd_done && !wr_done && cnt == CW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            last         <= 1'b1;
            rq0_ready    <= 1'b0;
            rq1_ready    <= 1'b0;
            rq0_rd_valid <= 1'b0;
            rq1_rd_valid <= 1'b0;
            rq0_rd       <= '0;
            rq1_rd       <= '0;
            mm_a         <= '0;
            mm_wd        <= '0;
            mm_read      <= 1'b0;
            mm_write     <= 1'b0;
            err_timeout  <= 1'b0;
            err_owner    <= 1'b0;
        end else begin
            rq0_ready    <= grant && !win;
            rq1_ready    <= grant && win;
            mm_read      <= grant && !win_wr;
            mm_write     <= grant && win_wr;
            rq0_rd_valid <= rd_done && !owner;
            rq1_rd_valid <= rd_done && owner;
            if (rd_done && !owner) rq0_rd <= mm_rd;
            if (rd_done && owner) rq1_rd <= mm_rd;
            if (grant) begin
                owner <= win;
                last  <= win;
                mm_a  <= (win ? rq1_a : rq0_a) & LINE_MASK;
                mm_wd <= win ? rq1_wd : rq0_wd;
                cnt   <= '0;
                state <= win_wr ? WR_WAIT : RD_WAIT;
            end else if (rd_done || wr_done) begin
                state <= IDLE;
            end else if (expire) begin
                state       <= IDLE;
                err_timeout <= 1'b1;
                err_owner   <= owner;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
